muldiv_unit: RTL and testbench

// - Iterative multiply/divide unit beside the single-cycle ALU in the EX stage; owns the HI/LO pair.
// - Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO on WIDTH-bit operands.
// - Multiplies by shift-add and divides by restoring division, one bit per cycle.
// - Uses a start/ready/done handshake so the pipeline stalls while busy; a flush input cancels an operation.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_if.sv | 31 +++
 rtl/muldiv_iter.sv | 74 +++++++
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encodings, FSM states and sign helper for the multiply/divide unit
// Purpose: shared definitions imported by muldiv_if, muldiv_iter and muldiv_unit.
// Ports: none (package).
package muldiv_pkg;

  // Op encodings; 6 and 7 are accepted in IDLE and do nothing.
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef logic [1:0] md_state_t;
  localparam md_state_t IDLE = 2'd0;
  localparam md_state_t CALC = 2'd1;
  localparam md_state_t FIX  = 2'd2;

  // Widest value abs_neg handles; callers zero-extend into it and cast the
  // result back, so any WIDTH up to 64 (2*WIDTH product) works.
  localparam int MD_XW = 128;

  function automatic logic [MD_XW-1:0] abs_neg(input logic [MD_XW-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/result bundle between the EX stage and the multiply/divide unit
// Purpose: groups the start/op/operand/flush request and the status/HI/LO results.
// Ports (master = pipeline side drives):
//   start, op[2:0], a, b, flush      request and cancel
//   in_ready, busy, done, div0       status back from the unit
//   hi, lo                           architectural HI/LO registers
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  in_ready, busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output in_ready, busy, done, div0, hi, lo
  );
endinterface

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one-bit-per-cycle shift-add multiply / restoring divide datapath
// Purpose: a shared 2W-bit shift register and W+1-bit adder/subtractor.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   load              load acc = {0, lo_init}, m = m_init
//   en                perform one iteration
//   is_div            1 = restoring-divide step, 0 = shift-add step
//   lo_init           multiplier (mult) or dividend (div) magnitude
//   m_init            multiplicand (mult) or divisor (div) magnitude
//   acc               mult: product; div: {remainder, quotient}
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   lo_init,
  input  logic [WIDTH-1:0]   m_init,
  output logic [2*WIDTH-1:0] acc
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH:0]     add_a, add_b, add_s;

  // Mult: upper half + multiplicand, carry kept in bit W.
  // Div: remainder shifted left with the next dividend bit, minus divisor;
  // bit W of the difference is the borrow (partial remainder < divisor).
  always_comb begin
    if (is_div) begin
      add_a = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      add_b = ~{1'b0, m_q};
      add_s = add_a + add_b + {{WIDTH{1'b0}}, 1'b1};
    end else begin
      add_a = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      add_b = {1'b0, m_q};
      add_s = add_a + add_b;
    end
  end

  always_comb begin
    acc_d = acc_q;
    m_d   = m_q;
    if (load) begin
      acc_d = {{WIDTH{1'b0}}, lo_init};
      m_d   = m_init;
    end else if (en) begin
      if (is_div) begin
        if (!add_s[WIDTH]) acc_d = {add_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else               acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
      end else begin
        if (acc_q[0]) acc_d = {add_s, acc_q[WIDTH-1:1]};
        else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      m_q   <= '0;
    end else begin
      acc_q <= acc_d;
      m_q   <= m_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit owning the HI/LO pair
// Purpose: MULT/MULTU/DIV/DIVU in WIDTH+1 cycles, MTHI/MTLO in place,
//          divide-by-zero short cut, flush cancels an in-flight op.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   bus (slave)       start/op/a/b/flush in; in_ready/busy/done/div0/hi/lo out
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  localparam int W2 = 2*WIDTH;

  md_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               dz_q, dz_d;
  logic               sq_q, sq_d;
  logic               sr_q, sr_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div0_q, div0_d;
  logic               div0_sv_q, div0_sv_d;

  logic               accept, op_arith, op_div, op_sgn, b_zero;
  logic               a_neg, b_neg, iter_load, iter_en;
  logic [WIDTH-1:0]   a_mag, b_mag, lo_init, m_init;
  logic [W2-1:0]      acc, mul_res;
  logic [WIDTH-1:0]   quo, rem;

  // Request decode; ops 0..3 are the arithmetic ones, bit0 = unsigned, bit1 = divide.
  always_comb begin
    accept   = bus.start & (state_q == IDLE) & ~bus.flush;
    op_arith = ~bus.op[2];
    op_div   = bus.op[1];
    op_sgn   = ~bus.op[0];
    b_zero   = (bus.b == '0);
    a_neg    = op_sgn & bus.a[WIDTH-1];
    b_neg    = op_sgn & bus.b[WIDTH-1];
    // MIN stays 2^(W-1) as an unsigned magnitude, so no saturation is needed.
    a_mag    = WIDTH'(abs_neg(MD_XW'(bus.a), a_neg));
    b_mag    = WIDTH'(abs_neg(MD_XW'(bus.b), b_neg));
    // A zero divisor loads the raw dividend so FIX can return it as HI.
    lo_init  = op_div ? (b_zero ? bus.a : a_mag) : b_mag;
    m_init   = op_div ? b_mag : a_mag;
    iter_load = accept & op_arith;
    iter_en   = (state_q == CALC);
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (iter_load),
    .en      (iter_en),
    .is_div  (is_div_q),
    .lo_init (lo_init),
    .m_init  (m_init),
    .acc     (acc)
  );

  // Sign fix-up of the unsigned core result.
  always_comb begin
    mul_res = W2'(abs_neg(MD_XW'(acc), sq_q));
    quo     = WIDTH'(abs_neg(MD_XW'(acc[WIDTH-1:0]), sq_q));
    rem     = WIDTH'(abs_neg(MD_XW'(acc[W2-1:WIDTH]), sr_q));
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (accept && op_arith) state_d = (op_div && b_zero) ? FIX : CALC;
        CALC: if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
        FIX:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM: outputs and register updates
  always_comb begin
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    dz_d      = dz_q;
    sq_d      = sq_q;
    sr_d      = sr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    div0_d    = div0_q;
    div0_sv_d = div0_sv_q;

    if (accept && op_arith) begin
      cnt_d     = '0;
      is_div_d  = op_div;
      dz_d      = op_div & b_zero;
      sq_d      = a_neg ^ b_neg;
      sr_d      = a_neg;
      div0_d    = 1'b0;
      // Remembered so a flush can put the flag back as it was before accept.
      div0_sv_d = div0_q;
    end
    if (accept && bus.op == MD_MTHI) hi_d = bus.a;
    if (accept && bus.op == MD_MTLO) lo_d = bus.a;

    if (state_q == CALC && !bus.flush) cnt_d = cnt_q + CNT_W'(1);

    if (state_q == FIX && !bus.flush) begin
      done_d = 1'b1;
      if (dz_q) begin
        lo_d   = '1;
        hi_d   = acc[WIDTH-1:0];
        div0_d = 1'b1;
      end else if (is_div_q) begin
        lo_d = quo;
        hi_d = rem;
      end else begin
        {hi_d, lo_d} = mul_res;
      end
    end

    if (bus.flush && state_q != IDLE) div0_d = div0_sv_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
      sq_q      <= 1'b0;
      sr_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
      div0_sv_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      dz_q      <= dz_d;
      sq_q      <= sq_d;
      sr_q      <= sr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
      div0_sv_q <= div0_sv_d;
    end
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.div0     = div0_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: results computed with plain 64-bit arithmetic at accept,
  // published after a fixed latency.
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  logic         m_div0, m_sv, m_busy, m_done, p_dz;
  int           m_rem;

  function automatic logic [2*W:0] ref_calc(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint        sa, sb, q, r;
    logic [63:0]   p;
    logic [W-1:0]  uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ref_calc = '0;
    case (op)
      MD_MULT: begin
        q = sa * sb;
        ref_calc = {1'b0, q[63:0]};
      end
      MD_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        ref_calc = {1'b0, p};
      end
      MD_DIV: begin
        if (b == '0) ref_calc = {1'b1, a, {W{1'b1}}};
        else begin
          q = sa / sb;
          r = sa % sb;
          ref_calc = {1'b0, r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == '0) ref_calc = {1'b1, a, {W{1'b1}}};
        else begin
          uq = a / b;
          ur = a % b;
          ref_calc = {1'b0, ur, uq};
        end
      end
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi <= '0; m_lo <= '0; m_div0 <= 1'b0; m_sv <= 1'b0;
      m_busy <= 1'b0; m_done <= 1'b0; m_rem <= 0;
      p_hi <= '0; p_lo <= '0; p_dz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (bus.flush) begin
        if (m_busy) begin
          m_busy <= 1'b0;
          m_div0 <= m_sv;
        end
      end else if (m_busy) begin
        if (m_rem == 1) begin
          m_busy <= 1'b0;
          m_hi   <= p_hi;
          m_lo   <= p_lo;
          m_done <= 1'b1;
          if (p_dz) m_div0 <= 1'b1;
        end
        m_rem <= m_rem - 1;
      end else if (bus.start) begin
        if (bus.op == MD_MTHI) m_hi <= bus.a;
        else if (bus.op == MD_MTLO) m_lo <= bus.a;
        else if (bus.op <= MD_DIVU) begin
          {p_dz, p_hi, p_lo} <= ref_calc(bus.op, bus.a, bus.b);
          m_sv   <= m_div0;
          m_div0 <= 1'b0;
          m_busy <= 1'b1;
          m_rem  <= (bus.op[1] && bus.b == '0) ? 1 : W + 1;
        end
      end
    end
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("hi", bus.hi, m_hi);
        chk("lo", bus.lo, m_lo);
        chk("div0", bus.div0, m_div0);
        chk("done", bus.done, m_done);
        chk("in_ready", bus.in_ready, !m_busy);
        chk("busy", bus.busy, m_busy);
      end
    end
  endtask

  // Drive a request for one cycle (accepted at the next posedge), then scramble
  // the operand lines to show they are not resampled.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'($urandom); bus.a = $urandom; bus.b = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("done_seen", bus.done, 1'b1);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    issue(op, a, b);
    wait_done(lat);
  endtask

  function automatic logic [W-1:0] pick(input bit allow_zero);
    case ($urandom_range(0, 7))
      0: return allow_zero ? '0 : 32'd1;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  int lat, n, dones;

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
    fork compare_loop(); join_none

    repeat (3) @(negedge clk);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_div0", bus.div0, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;

    run_op(MD_MULT, 32'hFFFF_FFFD, 32'h0000_0005, lat);
    chk("mult_lat", lat, 33);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFF1);
    chk("mult_in_ready", bus.in_ready, 1);
    @(negedge clk);
    chk("mult_done_pulse", bus.done, 0);

    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus.lo, 32'h0000_0001);
    run_op(MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    chk("mult_m1_hi", bus.hi, 0);
    chk("mult_m1_lo", bus.lo, 1);

    run_op(MD_DIV, 32'hFFFF_FFF9, 32'h2, lat);
    chk("div_lat", lat, 33);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);
    run_op(MD_DIVU, 32'h7, 32'h2, lat);
    chk("divu_lo", bus.lo, 3);
    chk("divu_hi", bus.hi, 1);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("minm1_lo", bus.lo, 32'h8000_0000);
    chk("minm1_hi", bus.hi, 0);
    chk("minm1_div0", bus.div0, 0);

    run_op(MD_DIVU, 32'h1234_5678, 32'h0, lat);
    chk("dz_lat", lat, 1);
    chk("dz_lo", bus.lo, 32'hFFFF_FFFF);
    chk("dz_hi", bus.hi, 32'h1234_5678);
    chk("dz_div0", bus.div0, 1);
    issue(MD_MULT, 32'd2, 32'd3);
    chk("div0_clear_at_accept", bus.div0, 0);
    wait_done(lat);
    chk("mult23_lo", bus.lo, 6);

    // MTLO then a MULT flushed at cnt=10.
    issue(MD_MTLO, 32'hCAFE_F00D, 32'h0);
    chk("mtlo_lo", bus.lo, 32'hCAFE_F00D);
    issue(MD_MULT, 32'd7, 32'd9);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_in_ready", bus.in_ready, 1);
    chk("flush_lo", bus.lo, 32'hCAFE_F00D);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("flush_no_done", dones, 0);

    // Start held through busy; a new request presented on the done cycle is taken.
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_MULTU; bus.a = 32'd3; bus.b = 32'd5;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.done) begin
        bus.op = 3'($urandom); bus.a = $urandom; bus.b = $urandom;
      end
    end while (!bus.done && n < 200);
    chk("held_done_seen", bus.done, 1);
    chk("held_lo", bus.lo, 15);
    chk("held_hi", bus.hi, 0);
    bus.op = MD_DIVU; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_cycle_accept", bus.busy, 1);
    wait_done(lat);
    chk("held_div_lo", bus.lo, 14);
    chk("held_div_hi", bus.hi, 2);

    // flush together with start in IDLE drops the request.
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = MD_MTHI; bus.a = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_start_drop", bus.hi, 2);

    // Asynchronous reset in the middle of CALC.
    issue(MD_MULT, 32'd11, 32'd13);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hi", bus.hi, 0);
    chk("arst_lo", bus.lo, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic with occasional flushes, checked every cycle by the model.
    repeat (3000) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 3) != 0);
      bus.op    = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      bus.a     = pick(1'b1);
      bus.b     = pick($urandom_range(0, 5) == 0);
      bus.flush = ($urandom_range(0, 60) == 0);
    end
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("quiesce", bus.busy, 0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
